// File: rtl/seq_feeder_pkg.sv
// Shared widths, buffer depth and FSM states
// for the query sequence feeder.
package seq_feeder_pkg;

  localparam int CHAR_W           = 3;
  localparam int BASE_W           = 2;
  localparam int BUFFER_DEPTH     = 8;
  localparam int BUFFER_DEPTH_BIT = 4;

  typedef enum logic [1:0] {
    SF_IDLE   = 2'd0,
    SF_STREAM = 2'd1,
    SF_DRAIN  = 2'd2,
    SF_DONE   = 2'd3
  } sf_state_e;

endpackage

// File: rtl/seq_feeder_if.sv
// SRAM read port and query Buffer drive bundle
// between the feeder and its neighbours.
interface seq_feeder_if #(
  parameter int ADDR_W = 10
);
  import seq_feeder_pkg::*;

  logic              mem_rd_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [BASE_W-1:0] mem_data_i;
  logic [CHAR_W-1:0] buf_q_o;
  logic              buf_pouring_o;
  logic              buf_update_o;

  modport master (
    output mem_rd_o,
    output mem_addr_o,
    input  mem_data_i,
    output buf_q_o,
    output buf_pouring_o,
    output buf_update_o
  );

  modport slave (
    input  mem_rd_o,
    input  mem_addr_o,
    output mem_data_i,
    input  buf_q_o,
    input  buf_pouring_o,
    input  buf_update_o
  );

endinterface

// File: rtl/seq_feeder_credit.sv
// Credit counter shadowing the query Buffer
// occupancy with the same next-edge update.
module seq_feeder_credit #(
  parameter  int DEPTH = 8,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  output logic [OCC_W-1:0] occ,
  output logic             empty,
  output logic             full
);

  // Push and pop together leave the count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
    end else begin
      unique case (1'b1)
        push && !pop: occ <= occ + OCC_W'(1);
        pop && !push: occ <= occ - OCC_W'(1);
        default:      occ <= occ;
      endcase
    end
  end

  assign empty = (occ == '0);
  assign full  = (occ == OCC_W'(DEPTH));

endmodule

// File: rtl/seq_feeder.sv
// Streams a query from SRAM into the Buffer FIFO.
// SEQ_FEEDER_STALL_CNT_EN adds stall_cnt_o.
module seq_feeder
  import seq_feeder_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11,
  parameter int DEPTH  = BUFFER_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              pe_req_i,
  output logic              busy_o,
  output logic              done_o,
`ifdef SEQ_FEEDER_STALL_CNT_EN
  output logic [15:0]       stall_cnt_o,
`endif
  seq_feeder_if.master      bus
);

  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam int NEED_W = OCC_W + 2;

  sf_state_e         state;
  sf_state_e         state_n;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  rd_cnt;
  logic [LEN_W-1:0]  push_cnt;
  logic              pend;
  logic [OCC_W-1:0]  occ;
  logic              occ_empty;
  logic              occ_full;
  logic              push;
  logic              pop;
  logic              active;
  logic              start_go;
  logic              issue_n;
  logic [ADDR_W-1:0] cur_base;
  logic [LEN_W-1:0]  cur_len;
  logic [LEN_W-1:0]  cur_rd;
  logic [NEED_W-1:0] need;

  seq_feeder_credit #(
    .DEPTH(DEPTH)
  ) u_credit (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .occ  (occ),
    .empty(occ_empty),
    .full (occ_full)
  );

  assign active = (state == SF_STREAM)
               || (state == SF_DRAIN);
  assign push   = pend;
  assign pop    = pe_req_i & ~occ_empty & active;

  // SRAM data is already a register output;
  // gating it keeps the push one cycle after the read.
  assign bus.buf_q_o      = pend ? {1'b1, bus.mem_data_i}
                                 : '0;
  assign bus.buf_update_o = pop;

  // Next state and next-cycle read decision.
  always_comb begin
    state_n  = state;
    start_go = 1'b0;
    cur_base = base_q;
    cur_len  = len_q;
    cur_rd   = rd_cnt;
    unique case (state)
      SF_IDLE: begin
        if (start_i) begin
          start_go = 1'b1;
          cur_base = base_addr_i;
          cur_len  = len_i;
          cur_rd   = '0;
          state_n  = (len_i == '0) ? SF_DONE
                                    : SF_STREAM;
        end
      end
      SF_STREAM: begin
        if (push && (push_cnt + LEN_W'(1) == len_q))
          state_n = SF_DRAIN;
      end
      SF_DRAIN: begin
        if (occ_empty && !pend)
          state_n = SF_DONE;
      end
      SF_DONE: state_n = SF_IDLE;
      default: state_n = SF_IDLE;
    endcase
    // A pop this cycle is ignored: one-cycle bubble.
    need    = NEED_W'(occ) + NEED_W'(pend)
            + NEED_W'(bus.mem_rd_o) + NEED_W'(1);
    issue_n = (state_n == SF_STREAM)
           && (cur_rd < cur_len)
           && (need <= NEED_W'(DEPTH));
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= SF_IDLE;
      base_q            <= '0;
      len_q             <= '0;
      rd_cnt            <= '0;
      push_cnt          <= '0;
      pend              <= 1'b0;
      bus.mem_rd_o      <= 1'b0;
      bus.mem_addr_o    <= '0;
      bus.buf_pouring_o <= 1'b0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
    end else begin
      state        <= state_n;
      pend         <= bus.mem_rd_o;
      bus.mem_rd_o <= issue_n;
      if (start_go) begin
        base_q <= base_addr_i;
        len_q  <= len_i;
      end
      if (issue_n) begin
        bus.mem_addr_o <= cur_base + ADDR_W'(cur_rd);
        rd_cnt         <= cur_rd + LEN_W'(1);
      end else if (start_go) begin
        rd_cnt <= '0;
      end
      if (start_go)
        push_cnt <= '0;
      else if (push)
        push_cnt <= push_cnt + LEN_W'(1);
      bus.buf_pouring_o <= (state_n == SF_STREAM);
      busy_o            <= (state_n != SF_IDLE);
      done_o            <= (state_n == SF_DONE);
    end
  end

`ifdef SEQ_FEEDER_STALL_CNT_EN
  // Cycles the PE array waited on an empty FIFO.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt_o <= '0;
    else if (start_go)
      stall_cnt_o <= '0;
    else if (pe_req_i && occ_empty && active
             && stall_cnt_o != 16'hFFFF)
      stall_cnt_o <= stall_cnt_o + 16'd1;
  end
`endif

  // The read pacing must never overrun the FIFO.
  a_no_overflow : assert property (
    @(posedge clk) disable iff (rst)
    !(occ_full && push && !pop)
  );

endmodule

// File: tb/tb_seq_feeder.sv
// Directed bench for seq_feeder with an SRAM
// model and a Buffer occupancy model.
module tb_seq_feeder;
  import seq_feeder_pkg::*;

  localparam int AW = 10;
  localparam int LW = 11;
  localparam int D  = BUFFER_DEPTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic          pe_req_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [LW-1:0] len_i = '0;
  logic          busy_o;
  logic          done_o;
`ifdef SEQ_FEEDER_STALL_CNT_EN
  logic [15:0]   stall_cnt_o;
`endif

  seq_feeder_if #(.ADDR_W(AW)) bus ();

  seq_feeder #(
    .ADDR_W(AW),
    .LEN_W (LW),
    .DEPTH (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .len_i      (len_i),
    .pe_req_i   (pe_req_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
`ifdef SEQ_FEEDER_STALL_CNT_EN
    .stall_cnt_o(stall_cnt_o),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic [1:0] mem [0:1023];
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int rd_addr[$];
  int rd_cyc[$];
  int push_q[$];
  int push_cyc[$];
  int pop_log[$];
  int model[$];
  int done_cnt = 0;
  int empty_gets = 0;
  int max_occ = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (bus.mem_rd_o)
      bus.mem_data_i <= mem[bus.mem_addr_o];

  always @(negedge clk) begin
    if (rst) begin
      model.delete();
    end else begin
      if (bus.mem_rd_o) begin
        rd_addr.push_back(int'(bus.mem_addr_o));
        rd_cyc.push_back(cyc);
      end
      if (bus.buf_update_o) begin
        if (model.size() == 0) empty_gets++;
        else pop_log.push_back(model.pop_front());
      end
      if (bus.buf_q_o[2]) begin
        model.push_back(int'(bus.buf_q_o));
        push_q.push_back(int'(bus.buf_q_o));
        push_cyc.push_back(cyc);
      end
      if (model.size() > max_occ)
        max_occ = model.size();
      if (done_o) done_cnt++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_addr.delete();
    rd_cyc.delete();
    push_q.delete();
    push_cyc.delete();
    pop_log.delete();
    done_cnt   = 0;
    empty_gets = 0;
    max_occ    = 0;
  endtask

  task automatic start_seq(input logic [AW-1:0] b,
                           input logic [LW-1:0] l,
                           output int t);
    start_i     = 1'b1;
    base_addr_i = b;
    len_i       = l;
    t           = cyc;
    tick();
    start_i     = 1'b0;
  endtask

  task automatic wait_done(input string tag,
                           input int budget,
                           output int dc);
    int n;
    n = 0;
    while (!done_o && n < budget) begin
      tick();
      n++;
    end
    dc = cyc;
    chk(tag, 32'(done_o), 1);
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.mem_rd_o, bus.mem_addr_o,
                bus.buf_q_o, bus.buf_pouring_o,
                bus.buf_update_o, busy_o, done_o});
  endfunction

  initial begin
    int t;
    int dc;
    int n;
    int k;
    logic [2:0] e;
    for (int i = 0; i < 1024; i++)
      mem[i] = 2'(i);

    // reset state
    repeat (3) tick();
    pe_req_i = 1'b1;
    tick();
    chk("rst_outs", outs(), 0);
`ifdef SEQ_FEEDER_STALL_CNT_EN
    chk("rst_stall", 32'(stall_cnt_o), 0);
`endif
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy_o), 0);

    // short sequence, pop on arrival
    clear_logs();
    for (int i = 0; i < 4; i++)
      mem[10'h10 + i] = 2'(i);
    start_seq(10'h10, 11'd4, t);
    chk("t1_rd_lat", 32'(bus.mem_rd_o), 1);
    wait_done("t1_done", 40, dc);
    chk("t1_done_cyc", 32'(dc - t), 8);
`ifdef SEQ_FEEDER_STALL_CNT_EN
    chk("t1_stall", 32'(stall_cnt_o), 3);
`endif
    tick();
    chk("t1_busy_end", 32'(busy_o), 0);
    chk("t1_done_pulse", 32'(done_o), 0);
    chk("t1_first_rd", 32'(rd_cyc[0] - t), 1);
    chk("t1_npush", 32'(push_q.size()), 4);
    chk("t1_ndone", 32'(done_cnt), 1);
    for (int i = 0; i < push_q.size() && i < 4; i++) begin
      e = {1'b1, 2'(i)};
      chk("t1_push_q", 32'(push_q[i]), 32'(e));
      chk("t1_push_cyc", 32'(push_cyc[i] - t),
          32'(2 + i));
    end
    chk("t1_npop", 32'(pop_log.size()), 4);

    // zero length
    clear_logs();
    start_seq(10'h0, 11'd0, t);
    chk("t3_done", 32'(done_o), 1);
    chk("t3_busy", 32'(busy_o), 1);
    tick();
    chk("t3_idle", 32'({busy_o, done_o}), 0);
    chk("t3_nrd", 32'(rd_addr.size()), 0);
    chk("t3_npush", 32'(push_q.size()), 0);

    // address wrap
    clear_logs();
    mem[10'h3FE] = 2'd3;
    mem[10'h3FF] = 2'd2;
    mem[10'h000] = 2'd1;
    mem[10'h001] = 2'd0;
    start_seq(10'h3FE, 11'd4, t);
    wait_done("t4_done", 40, dc);
    tick();
    chk("t4_nrd", 32'(rd_addr.size()), 4);
    if (rd_addr.size() == 4) begin
      chk("t4_a0", 32'(rd_addr[0]), 32'h3FE);
      chk("t4_a1", 32'(rd_addr[1]), 32'h3FF);
      chk("t4_a2", 32'(rd_addr[2]), 32'h000);
      chk("t4_a3", 32'(rd_addr[3]), 32'h001);
    end
    chk("t4_npush", 32'(push_q.size()), 4);
    if (push_q.size() == 4) begin
      chk("t4_q0", 32'(push_q[0]), 32'h7);
      chk("t4_q3", 32'(push_q[3]), 32'h4);
    end

    // backpressure
    clear_logs();
    pe_req_i = 1'b0;
    for (int i = 0; i < D + 5; i++)
      mem[10'h40 + i] = 2'(i) ^ 2'(i >> 2);
    start_seq(10'h40, 11'(D + 5), t);
    repeat (40) tick();
    chk("t2_npush_full", 32'(push_q.size()), D);
    chk("t2_nrd_full", 32'(rd_addr.size()), D);
    chk("t2_occ_full", 32'(model.size()), D);
    chk("t2_busy", 32'(busy_o), 1);
    pe_req_i = 1'b1;
    wait_done("t2_done", 300, dc);
    tick();
    chk("t2_npop", 32'(pop_log.size()), D + 5);
    for (int i = 0; i < pop_log.size(); i++) begin
      e = {1'b1, 2'(i) ^ 2'(i >> 2)};
      chk("t2_pop_q", 32'(pop_log[i]), 32'(e));
    end
    chk("t2_empty_get", 32'(empty_gets), 0);
    chk("t2_max_occ", 32'(max_occ), D);

    // reset mid-stream
    clear_logs();
    pe_req_i = 1'b0;
    start_seq(10'h80, 11'd6, t);
    n = 0;
    k = 0;
    while (n < 3 && k < 40) begin
      tick();
      k++;
      if (bus.buf_q_o[2]) n++;
    end
    chk("t5_push3", 32'(n), 3);
    rst      = 1'b1;
    pe_req_i = 1'b1;
    tick();
    chk("t5_rst_outs", outs(), 0);
`ifdef SEQ_FEEDER_STALL_CNT_EN
    chk("t5_rst_stall", 32'(stall_cnt_o), 0);
`endif
    rst = 1'b0;
    repeat (6) tick();
    chk("t5_no_done", 32'(done_cnt), 0);
    chk("t5_idle", 32'(busy_o), 0);

    // restart after reset
    clear_logs();
    mem[10'h90] = 2'd2;
    mem[10'h91] = 2'd1;
    start_seq(10'h90, 11'd2, t);
    wait_done("t6_done", 40, dc);
    tick();
    chk("t6_ndone", 32'(done_cnt), 1);
    chk("t6_npop", 32'(pop_log.size()), 2);
    if (pop_log.size() == 2) begin
      chk("t6_p0", 32'(pop_log[0]), 32'h6);
      chk("t6_p1", 32'(pop_log[1]), 32'h5);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
